// File: rtl/avfs_pkg.sv
// Shared types and constants for the AVFS frequency path.
// The level type is common to avfs_controller and avfs_freq_stepper.
package avfs_pkg;

   localparam int unsigned LEVEL_W   = 4;
   localparam int unsigned MAX_LEVEL = 15;

   typedef logic [LEVEL_W-1:0] level_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EDGE,
      SETTLE
   } step_state_t;

   // Divider reload for a level: period is MAX_LEVEL + 1 - lvl cycles.
   function automatic level_t reload_value(input level_t lvl);
      return level_t'(MAX_LEVEL) - lvl;
   endfunction

endpackage

// File: rtl/avfs_clk_div.sv
// Programmable down-counter producing a registered clock-enable pulse.
// The reload uses the level being applied on the same edge as the boundary.
module avfs_clk_div
   import avfs_pkg::*;
#(
   parameter int unsigned RESET_LEVEL = 0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  level_t next_level_i,
   output logic   clk_en_o,
   output logic   boundary_o
);

   level_t div_cnt_q, div_cnt_d;
   logic   clk_en_q;

   assign boundary_o = (div_cnt_q == '0);
   assign clk_en_o   = clk_en_q;

   always_comb begin
      div_cnt_d = div_cnt_q - level_t'(1);
      if (boundary_o) begin
         div_cnt_d = reload_value(next_level_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= reload_value(level_t'(RESET_LEVEL));
         clk_en_q  <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         clk_en_q  <= boundary_o;
      end
   end

endmodule

// File: rtl/avfs_freq_stepper.sv
// Slews the applied frequency level toward the requested target one step at a
// time, stepping only on divider boundaries and settling after each step.
module avfs_freq_stepper
   import avfs_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned RESET_LEVEL   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEVEL_W-1:0] freq_sel_i,
   output logic               clk_en_o,
   output logic [LEVEL_W-1:0] cur_level_o,
   output logic               busy_o,
   output logic               step_done_o
);

   localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

   step_state_t state_q, state_d;
   level_t      tgt_q;
   level_t      level_q, level_d;
   logic [7:0]  settle_cnt_q, settle_cnt_d;
   logic        step_done_q, step_done_d;
   logic        boundary;

   avfs_clk_div #(
      .RESET_LEVEL (RESET_LEVEL)
   ) u_clk_div (
      .clk          (clk),
      .rst_n        (rst_n),
      .next_level_i (level_d),
      .clk_en_o     (clk_en_o),
      .boundary_o   (boundary)
   );

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      settle_cnt_d = settle_cnt_q;
      step_done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tgt_q != level_q) begin
               state_d = WAIT_EDGE;
            end
         end
         WAIT_EDGE: begin
            // Target may have moved back onto the current level: abort quietly.
            if (tgt_q == level_q) begin
               state_d = IDLE;
            end else if (boundary) begin
               level_d      = (tgt_q > level_q) ? level_q + level_t'(1)
                                                : level_q - level_t'(1);
               settle_cnt_d = SettleLoad;
               state_d      = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d     = IDLE;
               step_done_d = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tgt_q        <= level_t'(RESET_LEVEL);
         level_q      <= level_t'(RESET_LEVEL);
         settle_cnt_q <= '0;
         step_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= freq_sel_i;
         level_q      <= level_d;
         settle_cnt_q <= settle_cnt_d;
         step_done_q  <= step_done_d;
      end
   end

   assign cur_level_o = level_q;
   assign busy_o      = (state_q != IDLE);
   assign step_done_o = step_done_q;

endmodule

// File: tb/tb_avfs_freq_stepper.sv
// Bench for avfs_freq_stepper: cycle reference model, vector table and
// directed multi-cycle scenarios, followed by randomized target changes.
module tb_avfs_freq_stepper;

   localparam int unsigned Settle = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] freq_sel = 4'd0;
   logic       clk_en;
   logic [3:0] cur_level;
   logic       busy;
   logic       step_done;

   always #5 clk = ~clk;

   avfs_freq_stepper #(
      .SETTLE_CYCLES (Settle),
      .RESET_LEVEL   (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .freq_sel_i  (freq_sel),
      .clk_en_o    (clk_en),
      .cur_level_o (cur_level),
      .busy_o      (busy),
      .step_done_o (step_done)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: m_cd = edges until the next enable pulse,
   // m_mode 0 = idle, 1 = waiting for a pulse, 2 = settling (m_left edges left).
   int m_lvl, m_tgt, m_cd, m_mode, m_left;
   int m_en, m_done;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lvl = 0; m_tgt = 0; m_cd = 16; m_mode = 0; m_left = 0; m_en = 0; m_done = 0;
   endtask

   task automatic model_step();
      int pulse, nl, nm, nd;
      pulse = (m_cd == 1);
      nl = m_lvl; nm = m_mode; nd = 0;
      if (m_mode == 0) begin
         if (m_tgt != m_lvl) nm = 1;
      end else if (m_mode == 1) begin
         if (m_tgt == m_lvl) nm = 0;
         else if (pulse != 0) begin
            nl = (m_tgt > m_lvl) ? m_lvl + 1 : m_lvl - 1;
            m_left = Settle;
            nm = 2;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            nm = 0;
            nd = 1;
         end
      end
      m_en   = pulse;
      m_cd   = (pulse != 0) ? 16 - nl : m_cd - 1;
      m_lvl  = nl;
      m_mode = nm;
      m_done = nd;
      m_tgt  = int'(freq_sel);
   endtask

   task automatic compare_model();
      check("model_clk_en", int'(clk_en), m_en);
      check("model_cur_level", int'(cur_level), m_lvl);
      check("model_busy", int'(busy), int'(m_mode != 0));
      check("model_step_done", int'(step_done), m_done);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step();
      compare_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Returns edges until the next enable pulse (40 if none arrives).
   task automatic count_to_pulse(output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (!clk_en && k < 40);
   endtask

   task automatic async_reset(input int hold);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_model();
      ticks(hold);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] fs;
      int         cycles;
      int         exp_lvl;
      int         exp_busy;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int k;
      int gap;
      int ndone;
      int maxl;
      int prev;
      int reversed;
      int seq[$];

      vecs.push_back('{4'd1, 1, 0, 0});
      vecs.push_back('{4'd1, 1, 0, 1});
      vecs.push_back('{4'd1, 40, 1, 0});
      vecs.push_back('{4'd3, 100, 3, 0});
      vecs.push_back('{4'd15, 400, 15, 0});
      vecs.push_back('{4'd7, 300, 7, 0});
      vecs.push_back('{4'd0, 300, 0, 0});

      // Reset
      model_reset();
      #1;
      check("rst_cur_level", int'(cur_level), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_clk_en", int'(clk_en), 0);
      check("rst_step_done", int'(step_done), 0);
      ticks(3);
      @(negedge clk);
      rst_n = 1'b1;
      count_to_pulse(k);
      check("first_clk_en_edges", k, 16);
      count_to_pulse(k);
      check("reset_period", k, 16);

      // Vector table
      foreach (vecs[i]) begin
         freq_sel = vecs[i].fs;
         ticks(vecs[i].cycles);
         check($sformatf("vec%0d_level", i), int'(cur_level), vecs[i].exp_lvl);
         check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].exp_busy);
      end

      // Ramp up 0 -> 3
      freq_sel = 4'd3;
      seq.delete();
      ndone = 0;
      gap = 100;
      for (int i = 0; i < 120; i++) begin
         prev = int'(cur_level);
         tick();
         gap++;
         if (step_done) ndone++;
         if (int'(cur_level) != prev) begin
            seq.push_back(int'(cur_level));
            check("ramp_step_on_boundary", int'(clk_en), 1);
            check("ramp_step_spacing_ge4", int'(gap >= 4), 1);
            gap = 0;
         end
      end
      check("ramp_num_steps", seq.size(), 3);
      if (seq.size() == 3) begin
         check("ramp_seq0", seq[0], 1);
         check("ramp_seq1", seq[1], 2);
         check("ramp_seq2", seq[2], 3);
      end
      check("ramp_step_done_count", ndone, 3);
      check("ramp_busy_end", int'(busy), 0);
      count_to_pulse(k);
      count_to_pulse(k);
      check("ramp_final_period", k, 13);

      // Full rate
      freq_sel = 4'd15;
      ticks(400);
      check("full_level", int'(cur_level), 15);
      check("full_busy", int'(busy), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("full_rate_clk_en", int'(clk_en), 1);
      end

      // Reversal 0 -> 5, turned back to 1 at level 2
      freq_sel = 4'd0;
      ticks(400);
      check("rev_start_level", int'(cur_level), 0);
      freq_sel = 4'd5;
      seq.delete();
      maxl = 0;
      reversed = 0;
      for (int i = 0; i < 300; i++) begin
         prev = int'(cur_level);
         tick();
         if (int'(cur_level) != prev) seq.push_back(int'(cur_level));
         if (int'(cur_level) > maxl) maxl = int'(cur_level);
         if (cur_level == 4'd2 && reversed == 0) begin
            freq_sel = 4'd1;
            reversed = 1;
         end
      end
      check("rev_num_steps", seq.size(), 3);
      if (seq.size() == 3) begin
         check("rev_seq0", seq[0], 1);
         check("rev_seq1", seq[1], 2);
         check("rev_seq2", seq[2], 1);
      end
      check("rev_max_level", maxl, 2);
      check("rev_final_level", int'(cur_level), 1);

      // Abort: 4 -> 5 request withdrawn while waiting for the boundary
      freq_sel = 4'd4;
      ticks(200);
      check("abort_start_level", int'(cur_level), 4);
      count_to_pulse(k);
      check("abort_sync_pulse", int'(clk_en), 1);
      freq_sel = 4'd5;
      ticks(2);
      check("abort_busy_seen", int'(busy), 1);
      freq_sel = 4'd4;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (step_done) ndone++;
      end
      check("abort_level", int'(cur_level), 4);
      check("abort_busy_end", int'(busy), 0);
      check("abort_no_step_done", ndone, 0);

      // Reset mid-SETTLE
      freq_sel = 4'd3;
      k = 0;
      while (cur_level == 4'd4 && k < 40) begin
         tick();
         k++;
      end
      check("midrst_in_settle", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_cur_level", int'(cur_level), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_clk_en", int'(clk_en), 0);
      model_reset();
      freq_sel = 4'd0;
      ticks(3);
      @(negedge clk);
      rst_n = 1'b1;
      count_to_pulse(k);
      check("midrst_first_clk_en", k, 16);
      count_to_pulse(k);
      check("midrst_period", k, 16);

      // Randomized targets against the model
      for (int s = 0; s < 60; s++) begin
         freq_sel = 4'($urandom_range(0, 15));
         ticks(int'($urandom_range(1, 45)));
         if ($urandom_range(0, 9) == 0) async_reset(int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/avfs_freq_stepper.md
# avfs_freq_stepper

Downstream stage of `avfs_controller`. It consumes the 4-bit `freq_sel` target and slews the operating frequency level toward it one step at a time. Each step is taken only on a divider period boundary and is followed by a fixed settle interval. From the current level it generates a single-cycle clock-enable pulse train, which gates the core clock domain's logic.

## Interface
- `SETTLE_CYCLES`, default 16: cycles spent in settle after each level step; legal range 1..255.
- `RESET_LEVEL`, default 0: value of `cur_level` at and after reset; legal range 0..15.
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst_n`  in  1  reset: asynchronous assertion, active-low.
- `freq_sel`  in  4  target level from `avfs_controller`. 0 is the slowest level and 15 is full rate.
- `clk_en`  out  1  registered enable pulse, one cycle high every `16 - cur_level` cycles.
- `cur_level`  out  4  currently applied level.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `step_done`  out  1  one-cycle pulse, high in the first IDLE cycle after a settle completes.

## Operation
- Target register: `tgt_q <= freq_sel` every cycle, which gives 1 cycle of input latency. Reset value is `RESET_LEVEL`.
- Divider:
  - Down-counter `div_cnt` (4 bits).
  - Each edge with `div_cnt == 0`: `clk_en <= 1` and `div_cnt <= 15 - next_level`.
  - Any other edge: `clk_en <= 0` and `div_cnt <= div_cnt - 1`.
  - `next_level` is the level being written on that same edge, so the reload uses the new level. Period = `16 - level` (level 15 gives `clk_en` high every cycle; level 0 gives one pulse in 16).
- FSM states are IDLE, WAIT_EDGE and SETTLE.
  - IDLE: if `tgt_q != cur_level`, go to WAIT_EDGE. Otherwise stay.
  - WAIT_EDGE, on an edge where `div_cnt == 0`:
    - If `tgt_q > cur_level`, then `cur_level++`.
    - If `tgt_q < cur_level`, then `cur_level--`.
    - In both of those cases, load `settle_cnt <= SETTLE_CYCLES - 1` and go to SETTLE.
    - If `tgt_q == cur_level` (target moved back), return to IDLE with no step and no `step_done`.
    - On an edge with `div_cnt != 0`, the equality abort still applies: return to IDLE when `tgt_q == cur_level`.
  - SETTLE: decrement `settle_cnt`. On the edge where `settle_cnt == 0`, go to IDLE and set `step_done <= 1` for one cycle.
- Direction is re-evaluated at every step, so a target reversal mid-ramp never overshoots by more than the step already in progress.
- `cur_level` changes by exactly ±1 per step and never wraps; it saturates naturally at 0 and 15 because the target is bounded.
- Target changes during SETTLE are absorbed into `tgt_q` but do not shorten the settle interval.
- Reset values, which also apply immediately on async reset mid-operation:
  - state IDLE
  - `cur_level = RESET_LEVEL`, `tgt_q = RESET_LEVEL`
  - `div_cnt = 15 - RESET_LEVEL`
  - `settle_cnt = 0`
  - `clk_en = 0`, `busy = 0`, `step_done = 0`

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `freq_sel` change to `busy` high: 2 cycles (1 for `tgt_q`, 1 for IDLE→WAIT_EDGE).
- WAIT_EDGE dwell: 1 to `16 - cur_level` cycles, depending on the divider phase.
- The `clk_en` pulse coincident with a step uses the old period; the following pulse is spaced by the new period.
- SETTLE dwell: exactly `SETTLE_CYCLES` cycles.
- `step_done` high in the IDLE cycle following SETTLE. If the target is still unmet, `busy` re-asserts on the next edge.
- First `clk_en` after reset release: after `16 - RESET_LEVEL` edges.

## Structure
- `avfs_pkg` holds:
  - `LEVEL_W = 4` and `MAX_LEVEL = 15`
  - `typedef enum logic [1:0] {IDLE, WAIT_EDGE, SETTLE} step_state_t`
  - the `level_t` typedef, shared with `avfs_controller`.
- Sub-module `avfs_clk_div` contains the divider.
  - Inputs: `clk`, `rst_n`, `next_level`.
  - Outputs: `clk_en` and `boundary` (`div_cnt == 0`).
- The FSM and the level and settle registers live in the top module.

## Test plan
Benches use `SETTLE_CYCLES = 4` and `RESET_LEVEL = 0`.
- Reset: hold `rst_n = 0` with `freq_sel = 0`, then release -> `cur_level = 0`, `busy = 0`, `clk_en = 0` during reset; first `clk_en` on the 16th edge, then every 16 cycles.
- Ramp up: `freq_sel = 3` -> `cur_level` steps 1, 2, 3, each on a divider boundary, at least 4 cycles apart; 3 `step_done` pulses; final `clk_en` period 13; `busy` low at the end.
- Full rate: ramp `freq_sel` to 15 -> after the last step `clk_en` is high every cycle; `cur_level = 15`.
- Reversal: from 0 set `freq_sel = 5`; once `cur_level = 2`, set `freq_sel = 1` -> level sequence 1, 2, 1, never reaches 3.
- Abort: from level 4 set `freq_sel = 5`, then drive 4 back while in WAIT_EDGE before the boundary -> return to IDLE, `cur_level` stays 4, no `step_done`.
- Reset mid-SETTLE: assert `rst_n = 0` while `busy = 1` -> same cycle `cur_level = 0`, `busy = 0`, `clk_en = 0`; after release, behaviour is identical to the Reset scenario.
